// File: rtl/imul_result_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imul_result_queue: credit-managed result FIFO behind the integer         |
// | multiplier. Optional same-cycle bypass: IMUL_RESULT_QUEUE_BYPASS_EN.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module imul_result_queue #(
    parameter int NBITS = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issue,
    output logic                     issue_ok,
    input  logic                     in_val,
    input  logic [NBITS-1:0]         in_msg,
    output logic                     out_val,
    input  logic                     out_rdy,
    output logic [NBITS-1:0]         out_msg,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;
    localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);

    logic [NBITS-1:0] mem [DEPTH];

    logic [c_aw-1:0] wptr_q, wptr_d;
    logic [c_aw-1:0] rptr_q, rptr_d;
    logic [c_cw-1:0] count_q, count_d;
    logic [c_cw-1:0] credits_q, credits_d;
    logic            overflow_q, overflow_d;

    logic             w_empty;
    logic             w_full;
    logic [NBITS-1:0] w_head;
    logic             w_bypass_take;
    logic             w_deq;
    logic             w_enq;
    logic             w_drop;
    logic             w_issue_take;
    logic             w_issue_err;
    logic             w_credit_ret;

    always_comb begin
        w_empty = (count_q == '0);
        w_full  = (count_q == c_depth);
        w_head  = mem[rptr_q];
`ifdef IMUL_RESULT_QUEUE_BYPASS_EN
        // An in-flight result is discarded while reset is held, so it must not leak out.
        w_bypass_take = w_empty && in_val && out_rdy && reset;
        out_val       = !w_empty || (in_val && reset);
        out_msg       = !w_empty ? w_head : ((in_val && reset) ? in_msg : '0);
`else
        w_bypass_take = 1'b0;
        out_val       = !w_empty;
        out_msg       = !w_empty ? w_head : '0;
`endif
        w_deq        = !w_empty && out_rdy;
        // A full queue still accepts a result when the head leaves in the same cycle.
        w_enq        = in_val && !w_bypass_take && (!w_full || w_deq);
        w_drop       = in_val && w_full && !w_deq;
        w_issue_take = issue && (credits_q != '0);
        w_issue_err  = issue && (credits_q == '0);
        w_credit_ret = w_deq || w_bypass_take;
    end

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        credits_d  = credits_q;
        overflow_d = overflow_q | w_drop | w_issue_err;

        if (w_enq) begin
            wptr_d = wptr_q + c_aw'(1);
        end
        if (w_deq) begin
            rptr_d = rptr_q + c_aw'(1);
        end

        case ({w_enq, w_deq})
            2'b10:   count_d = count_q + c_cw'(1);
            2'b01:   count_d = count_q - c_cw'(1);
            default: count_d = count_q;
        endcase

        // Saturate at DEPTH so a stray result with no matching issue cannot inflate credits.
        if (w_issue_take && !w_credit_ret) begin
            credits_d = credits_q - c_cw'(1);
        end else if (w_credit_ret && !w_issue_take && (credits_q != c_depth)) begin
            credits_d = credits_q + c_cw'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            credits_q  <= c_depth;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            credits_q  <= credits_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            mem[wptr_q] <= in_msg;
        end
    end

    assign issue_ok = (credits_q != '0);
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_imul_result_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_imul_result_queue: directed self-checking bench for the result queue. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_imul_result_queue;

    logic        clk;
    logic        reset;
    logic        issue;
    logic        issue_ok;
    logic        in_val;
    logic [31:0] in_msg;
    logic        out_val;
    logic        out_rdy;
    logic [31:0] out_msg;
    logic [2:0]  count;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    imul_result_queue #(.NBITS(32), .DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .issue    (issue),
        .issue_ok (issue_ok),
        .in_val   (in_val),
        .in_msg   (in_msg),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_msg  (out_msg),
        .count    (count),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic iss, input logic iv, input logic [31:0] msg, input logic rdy);
        issue   = iss;
        in_val  = iv;
        in_msg  = msg;
        out_rdy = rdy;
    endtask

    task automatic cyc(input logic iss, input logic iv, input logic [31:0] msg, input logic rdy);
        set_in(iss, iv, msg, rdy);
        tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_out_val"},  32'(out_val),  32'd0);
        chk({tag, "_out_msg"},  out_msg,       32'd0);
        chk({tag, "_count"},    32'(count),    32'd0);
        chk({tag, "_issue_ok"}, 32'(issue_ok), 32'd1);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    logic        rdy_pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        iss;
    logic        pend;
    logic [31:0] pend_val;
    int          issued;
    int          exp_out;
    int          cyc_n;

    initial begin
        reset = 1'b1;
        set_in(1'b0, 1'b0, 32'd0, 1'b0);

        // Reset and idle
        #2 reset = 1'b0;
        #1 chk_idle("reset_async");
        repeat (3) begin
            tick();
            chk_idle("reset_hold");
        end
        reset = 1'b1;
        tick();
        chk_idle("idle1");
        tick();
        chk_idle("idle2");

        // Fill and drain
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        chk("fill_issue_ok0", 32'(issue_ok), 32'd1);
        chk("fill_count0", 32'(count), 32'd0);
        cyc(1'b1, 1'b1, 32'h6, 1'b0);
        chk("fill_latency_val", 32'(out_val), 32'd1);
        chk("fill_latency_msg", out_msg, 32'h6);
        chk("fill_count1", 32'(count), 32'd1);
        cyc(1'b1, 1'b1, 32'h15, 1'b0);
        cyc(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
        chk("fill_issue_ok_drop", 32'(issue_ok), 32'd0);
        chk("fill_count3", 32'(count), 32'd3);
        cyc(1'b0, 1'b1, 32'h0, 1'b0);
        chk("fill_count4", 32'(count), 32'd4);
        chk("fill_issue_ok_full", 32'(issue_ok), 32'd0);
        chk("fill_head", out_msg, 32'h6);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        chk("drain_issue_ok_back", 32'(issue_ok), 32'd1);
        chk("drain_count3", 32'(count), 32'd3);
        chk("drain_msg2", out_msg, 32'h15);
        tick();
        chk("drain_msg3", out_msg, 32'hFFFF_FFFE);
        chk("drain_count2", 32'(count), 32'd2);
        tick();
        chk("drain_val4", 32'(out_val), 32'd1);
        chk("drain_msg4", out_msg, 32'h0);
        chk("drain_count1", 32'(count), 32'd1);
        tick();
        chk("drain_empty_val", 32'(out_val), 32'd0);
        chk("drain_empty_count", 32'(count), 32'd0);
        chk("drain_empty_issue_ok", 32'(issue_ok), 32'd1);

        // Full with simultaneous enqueue and dequeue
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        cyc(1'b1, 1'b1, 32'd1, 1'b0);
        cyc(1'b1, 1'b1, 32'd2, 1'b0);
        cyc(1'b1, 1'b1, 32'd3, 1'b0);
        cyc(1'b0, 1'b1, 32'd4, 1'b0);
        chk("simul_full", 32'(count), 32'd4);
        set_in(1'b0, 1'b1, 32'd5, 1'b1);
        #1 chk("simul_head_pre", out_msg, 32'd1);
        tick();
        chk("simul_count", 32'(count), 32'd4);
        chk("simul_msg2", out_msg, 32'd2);
        set_in(1'b0, 1'b0, 32'd0, 1'b1);
        tick();
        chk("simul_msg3", out_msg, 32'd3);
        tick();
        chk("simul_msg4", out_msg, 32'd4);
        tick();
        chk("simul_msg5", out_msg, 32'd5);
        tick();
        chk("simul_empty", 32'(out_val), 32'd0);
        chk("simul_overflow", 32'(overflow), 32'd0);
        set_in(1'b0, 1'b0, 32'd0, 1'b0);

        // Overflow on a full queue, then asynchronous reset mid-operation
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        cyc(1'b1, 1'b1, 32'h11, 1'b0);
        cyc(1'b1, 1'b1, 32'h22, 1'b0);
        cyc(1'b1, 1'b1, 32'h33, 1'b0);
        cyc(1'b0, 1'b1, 32'h44, 1'b0);
        chk("ovf_full", 32'(count), 32'd4);
        cyc(1'b0, 1'b1, 32'hAA, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd4);
        chk("ovf_head", out_msg, 32'h11);
        cyc(1'b0, 1'b0, 32'd0, 1'b0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        chk("ovf_drain2", out_msg, 32'h22);
        tick();
        chk("ovf_drain3", out_msg, 32'h33);
        chk("ovf_count2", 32'(count), 32'd2);
        set_in(1'b0, 1'b0, 32'd0, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("async_count", 32'(count), 32'd0);
        chk("async_out_val", 32'(out_val), 32'd0);
        chk("async_out_msg", out_msg, 32'd0);
        chk("async_overflow", 32'(overflow), 32'd0);
        chk("async_issue_ok", 32'(issue_ok), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        chk_idle("post_reset");

        // Issue without a credit
        repeat (4) cyc(1'b1, 1'b0, 32'd0, 1'b0);
        chk("credit_exhausted", 32'(issue_ok), 32'd0);
        chk("credit_no_ovf", 32'(overflow), 32'd0);
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        chk("credit_ovf", 32'(overflow), 32'd1);
        chk("credit_ok_stays0", 32'(issue_ok), 32'd0);
        cyc(1'b0, 1'b0, 32'd0, 1'b0);
        chk("credit_no_underflow", 32'(issue_ok), 32'd0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk_idle("post_reset2");

        // Wrap-around streaming of 1..20 with a throttled consumer
        issued   = 0;
        exp_out  = 1;
        cyc_n    = 0;
        pend     = 1'b0;
        pend_val = 32'd0;
        while (exp_out <= 20 && cyc_n < 300) begin
            iss = issue_ok && (issued < 20);
            set_in(iss, pend, pend_val, rdy_pat[cyc_n % 5]);
            #1;
            if (out_val && out_rdy) begin
                chk("stream_order", out_msg, 32'(exp_out));
                exp_out++;
            end
            tick();
            chk("stream_invariant", 32'(dut.credits_q) + 32'(count) + 32'(iss), 32'd4);
            pend = iss;
            if (iss) begin
                issued++;
                pend_val = 32'(issued);
            end
            cyc_n++;
        end
        chk("stream_all_out", 32'(exp_out), 32'd21);
        chk("stream_no_ovf", 32'(overflow), 32'd0);
        set_in(1'b0, 1'b0, 32'd0, 1'b0);
        tick();

        // Bypass path (or one-cycle latency without it)
        set_in(1'b0, 1'b1, 32'h2A, 1'b1);
        #1;
`ifdef IMUL_RESULT_QUEUE_BYPASS_EN
        chk("bypass_val", 32'(out_val), 32'd1);
        chk("bypass_msg", out_msg, 32'h2A);
        tick();
        set_in(1'b0, 1'b0, 32'd0, 1'b0);
        chk("bypass_count", 32'(count), 32'd0);
        chk("bypass_after_val", 32'(out_val), 32'd0);
`else
        chk("nobypass_val", 32'(out_val), 32'd0);
        chk("nobypass_msg", out_msg, 32'd0);
        tick();
        set_in(1'b0, 1'b0, 32'd0, 1'b1);
        chk("nobypass_count", 32'(count), 32'd1);
        chk("nobypass_late_val", 32'(out_val), 32'd1);
        chk("nobypass_late_msg", out_msg, 32'h2A);
        tick();
        chk("nobypass_drained", 32'(count), 32'd0);
        set_in(1'b0, 1'b0, 32'd0, 1'b0);
`endif
        chk("final_overflow", 32'(overflow), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
